alu_serial_ctrl: RTL and testbench



---
 rtl/alu_serial_ctrl.sv | 163 ++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_serial_ctrl                                              |
// | Description : Bit-serial sequencer driving one 1-bit ALU slice LSB first.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_serial_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("alu_serial_ctrl: WIDTH must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_last;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [3:0]        r_op;
    logic              r_carry;
    logic [CW-1:0]     r_cnt;
    // Holds the first WIDTH-1 result bits; the final bit joins them at the last step.
    logic [WIDTH-2:0]  r_shift;

    logic              w_ai;
    logic              w_bi;
    logic              w_sum;
    logic              w_cout;
    logic              w_bit;
    logic              w_ovf;
    logic              w_less;
    logic [WIDTH-1:0]  w_final;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        w_accept = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == c_last) begin
                    w_last = 1'b1;
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------ bit slice
    always_comb begin
        w_ai   = r_a[0] ^ r_op[3];
        w_bi   = r_b[0] ^ r_op[2];
        w_sum  = w_ai ^ w_bi ^ r_carry;
        w_cout = (w_ai & w_bi) | (w_ai & r_carry) | (w_bi & r_carry);
        case (r_op[1:0])
            2'b00:   w_bit = w_ai & w_bi;
            2'b01:   w_bit = w_ai | w_bi;
            default: w_bit = w_sum;
        endcase
        // Only meaningful on the MSB step, which is the only time it is used.
        w_ovf  = r_carry ^ w_cout;
        w_less = w_sum ^ w_ovf;
        if (r_op[1:0] == 2'b11) begin
            w_final = {{(WIDTH-1){1'b0}}, w_less};
        end else begin
            w_final = {w_bit, r_shift};
        end
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_shift <= '0;
            result  <= '0;
            zero    <= 1'b1;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_carry <= op[2];
            r_cnt   <= '0;
        end else if (busy) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_cout;
            r_shift <= (WIDTH-1)'({w_bit, r_shift} >> 1);
            if (w_last) begin
                r_cnt  <= '0;
                result <= w_final;
                zero   <= (w_final == '0);
                cout   <= w_cout;
                ovf    <= r_op[1] & w_ovf;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_serial_ctrl                                           |
// | Description : Self-checking bench for alu_serial_ctrl, arithmetic model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_serial_ctrl;

    localparam int W = 64;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   op    = '0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         cout;
    logic         ovf;

    int           pass_cnt = 0;
    int           chk_cnt  = 0;
    logic [W-1:0] last_res = '0;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Whole-word reference: invert, add with carry-in, then select.
    task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic z, output logic c, output logic v);
        logic [W-1:0] ai, bi;
        logic [W:0]   s;
        logic         sov;
        ai  = o[3] ? ~x : x;
        bi  = o[2] ? ~y : y;
        s   = {1'b0, ai} + {1'b0, bi} + (W+1)'(o[2]);
        sov = (ai[W-1] == bi[W-1]) && (s[W-1] != ai[W-1]);
        c   = s[W];
        v   = o[1] ? sov : 1'b0;
        case (o[1:0])
            2'b00:   r = ai & bi;
            2'b01:   r = ai | bi;
            2'b10:   r = s[W-1:0];
            default: r = {{(W-1){1'b0}}, s[W-1] ^ sov};
        endcase
        z = (r == '0);
    endtask

    // Entered #1 after the accepting edge; returns #1 after the edge that ends DONE
    // (or, with keep_start, #1 after the edge that enters DONE).
    task automatic finish_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                             input bit keep_start, input bit poke);
        logic [W-1:0] er;
        logic         ez, ec, ev;
        int           n     = 0;
        int           nbusy = 0;
        bit           stable = 1'b1;
        model(o, x, y, er, ez, ec, ev);
        while (!done && n < 3*W) begin
            if (busy) nbusy++;
            if (result !== last_res) stable = 1'b0;
            if (poke) start = 1'($urandom % 2);
            @(posedge clk); #1;
            n++;
        end
        if (!keep_start) start = 1'b0;
        // n edges until done is visible; it is captured at the following edge
        check("done_latency", n + 1, W + 1);
        check("busy_cycles", nbusy, W);
        check("result_held", stable, 1);
        check("result", result, er);
        check("zero", zero, ez);
        check("cout", cout, ec);
        check("ovf", ovf, ev);
        last_res = er;
        if (!keep_start) begin
            @(posedge clk); #1;
            check("done_pulse", done, 0);
            check("busy_after", busy, 0);
        end
    endtask

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit poke);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        finish_op(o, x, y, 1'b0, poke);
    endtask

    function automatic logic [W-1:0] rnd_operand();
        logic [W-1:0] v;
        case ($urandom % 6)
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b1, {(W-1){1'b0}}};
            3:       v = {1'b0, {(W-1){1'b1}}};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        logic seen_done;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);

        // directed cases
        run_op(4'b0010, 64'd5, 64'd3, 1'b0);
        check("add_result", result, 64'd8);
        run_op(4'b0110, 64'd3, 64'd5, 1'b0);
        check("sub_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(4'b0110, 64'h1234, 64'h1234, 1'b0);
        check("sub_zero", zero, 1);
        run_op(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        check("ovf_result", result, 64'h8000_0000_0000_0000);
        run_op(4'b0111, '1, 64'd1, 1'b0);
        check("slt_neg", result, 64'd1);
        run_op(4'b0111, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
        check("slt_ovf", ovf, 1);
        run_op(4'b0111, 64'd1, '1, 1'b0);
        check("slt_pos", result, 64'd0);

        // NOR then AND back to back with start held high
        @(negedge clk);
        op = 4'b1100; a = '0; b = '0; start = 1'b1;
        @(posedge clk); #1;
        op = 4'b0000; a = 64'hF0; b = 64'h3C;
        finish_op(4'b1100, '0, '0, 1'b1, 1'b0);
        check("nor_result", result, '1);
        @(posedge clk); #1;
        start = 1'b0;
        finish_op(4'b0000, 64'hF0, 64'h3C, 1'b0, 1'b0);
        check("b2b_result", result, 64'h30);

        // start noise during RUN
        run_op(4'b0010, 64'd100, 64'd23, 1'b1);

        // reset while bit 20 is being processed
        @(negedge clk);
        op = 4'b0010; a = 64'd77; b = 64'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_zero", zero, 1);
        check("abort_cout", cout, 0);
        check("abort_ovf", ovf, 0);
        seen_done = 1'b0;
        repeat (2*W) begin
            @(posedge clk); #1;
            seen_done = seen_done | done;
        end
        check("abort_no_done", seen_done, 0);
        last_res = '0;
        run_op(4'b0010, 64'd40, 64'd2, 1'b0);

        // randomized sweep over all op codes and corner operands
        for (int i = 0; i < 40; i++) begin
            run_op(4'($urandom % 16), rnd_operand(), rnd_operand(), 1'($urandom % 2));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
